// File: rtl/multicycle_control_unit.sv
// Multicycle RV32 subset control FSM: fetch/decode/execute/memory/writeback
// sequencing, datapath select generation, sticky illegal trap and retire counter.
module multicycle_control_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 3,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [DATA_WIDTH-1:0]    instr_i,
  input  logic                     mem_ready_i,
  input  logic                     zero_i,
  input  logic                     lt_i,
  output logic                     mem_req_o,
  output logic                     ir_we_o,
  output logic                     pc_we_o,
  output logic [1:0]               reg_write_o,
  output logic [1:0]               mem_write_o,
  output logic [1:0]               result_src_o,
  output logic [CONTROL_WIDTH-1:0] alu_ctrl_o,
  output logic                     alu_src_o,
  output logic [2:0]               imm_src_o,
  output logic [1:0]               pc_src_o,
  output logic                     illegal_o,
  output logic [2:0]               state_o,
  output logic [CNT_WIDTH-1:0]     instret_o
);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2,
    MEMORY = 3'd3, WRITEBACK = 3'd4, HALT = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_R    = 7'b0110011, OP_IALU  = 7'b0010011,
                         OP_BR   = 7'b1100011, OP_JAL   = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI   = 7'b0110111;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  ir_q;
  logic                   illegal_q;
  logic [CNT_WIDTH-1:0]   instret_q;
  logic                   retire;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_load, is_store, is_branch, legal, taken, alu_src;
  logic [2:0] alu_sel, imm_sel;
  logic [1:0] width_code;
  logic       ir_unused;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BR);
  assign ir_unused = ^{ir_q[DATA_WIDTH-1:31], ir_q[29:15], ir_q[11:7]};

  // byte/half/word size code shared by load write-back and store strobes
  assign width_code = (funct3 == 3'b010) ? 2'b01 :
                      (funct3 == 3'b001) ? 2'b10 : 2'b11;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE:        legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      OP_R, OP_JAL, OP_LUI:     legal = 1'b1;
      OP_IALU:                  legal = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                                        (funct3 == 3'b010) || (funct3 == 3'b101);
      OP_BR:                    legal = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                                        (funct3 == 3'b100) || (funct3 == 3'b101);
      OP_JALR:                  legal = (funct3 == 3'b000);
      default:                  legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_sel = 3'b000;
    alu_src = 1'b0;
    imm_sel = 3'b000;
    case (opcode)
      OP_LOAD:  alu_src = 1'b1;
      OP_STORE: begin alu_src = 1'b1; imm_sel = 3'b001; end
      OP_R:     alu_sel = (funct3 == 3'b000 && ir_q[30]) ? 3'b001 : 3'b000;
      OP_IALU: begin
        alu_src = 1'b1;
        case (funct3)
          3'b001:  alu_sel = 3'b101;
          3'b010:  alu_sel = 3'b110;
          3'b101:  alu_sel = 3'b111;
          default: alu_sel = 3'b000;
        endcase
      end
      OP_BR:    begin imm_sel = 3'b010; alu_sel = funct3[2] ? 3'b110 : 3'b001; end
      OP_JAL:   imm_sel = 3'b011;
      OP_JALR:  alu_src = 1'b1;
      OP_LUI:   imm_sel = 3'b100;
      default:  alu_sel = 3'b000;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = zero_i;
      3'b001:  taken = !zero_i;
      3'b100:  taken = lt_i;
      3'b101:  taken = !lt_i;
      default: taken = 1'b0;
    endcase
  end

  // outputs held at zero while reset is asserted so nothing leaks out mid-reset
  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    reg_write_o  = 2'b00;
    mem_write_o  = 2'b00;
    result_src_o = 2'b00;
    alu_ctrl_o   = '0;
    alu_src_o    = 1'b0;
    imm_src_o    = 3'b000;
    pc_src_o     = 2'b00;
    retire       = 1'b0;
    if (rst_ni) begin
      case (state_q)
        FETCH: begin
          mem_req_o = 1'b1;
          if (mem_ready_i) begin
            ir_we_o = 1'b1;
            state_d = DECODE;
          end
        end
        DECODE: state_d = legal ? EXECUTE : HALT;
        EXECUTE: begin
          alu_ctrl_o = CONTROL_WIDTH'(alu_sel);
          alu_src_o  = alu_src;
          imm_src_o  = imm_sel;
          if (is_load || is_store) state_d = MEMORY;
          else if (is_branch) begin
            pc_we_o  = 1'b1;
            pc_src_o = taken ? 2'b01 : 2'b00;
            retire   = 1'b1;
            state_d  = FETCH;
          end else state_d = WRITEBACK;
        end
        MEMORY: begin
          mem_req_o = 1'b1;
          if (is_store) mem_write_o = width_code;
          if (mem_ready_i) begin
            if (is_store) begin
              pc_we_o = 1'b1;
              retire  = 1'b1;
              state_d = FETCH;
            end else state_d = WRITEBACK;
          end
        end
        WRITEBACK: begin
          pc_we_o     = 1'b1;
          retire      = 1'b1;
          state_d     = FETCH;
          reg_write_o = is_load ? width_code : 2'b01;
          case (opcode)
            OP_LOAD: result_src_o = 2'b01;
            OP_JAL:  begin result_src_o = 2'b10; pc_src_o = 2'b01; imm_src_o = 3'b011; end
            OP_JALR: begin result_src_o = 2'b10; pc_src_o = 2'b10; end
            OP_LUI:  begin result_src_o = 2'b11; imm_src_o = 3'b100; end
            default: result_src_o = 2'b00;
          endcase
        end
        HALT:    state_d = HALT;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (ir_we_o)           ir_q      <= instr_i;
      if (state_d == HALT)   illegal_q <= 1'b1;
      if (retire)            instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  assign illegal_o = illegal_q;
  assign state_o   = state_q;
  assign instret_o = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle expected output
// vectors go through a scoreboard queue; a 4-bit counter copy checks wrap.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        rdy, zero, lt;

  logic        mem_req, ir_we, pc_we, alu_src, illegal;
  logic [1:0]  rw, mw, rs, pcs;
  logic [2:0]  alu, imm, state;
  logic [31:0] instret;

  logic        mem_req4, ir_we4, pc_we4, alu_src4, illegal4;
  logic [1:0]  rw4, mw4, rs4, pcs4;
  logic [2:0]  alu4, imm4, state4;
  logic [3:0]  instret4;

  logic [21:0] obs, obs4;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .mem_ready_i(rdy),
    .zero_i(zero), .lt_i(lt), .mem_req_o(mem_req), .ir_we_o(ir_we),
    .pc_we_o(pc_we), .reg_write_o(rw), .mem_write_o(mw), .result_src_o(rs),
    .alu_ctrl_o(alu), .alu_src_o(alu_src), .imm_src_o(imm), .pc_src_o(pcs),
    .illegal_o(illegal), .state_o(state), .instret_o(instret)
  );

  multicycle_control_unit #(.CNT_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .mem_ready_i(rdy),
    .zero_i(zero), .lt_i(lt), .mem_req_o(mem_req4), .ir_we_o(ir_we4),
    .pc_we_o(pc_we4), .reg_write_o(rw4), .mem_write_o(mw4), .result_src_o(rs4),
    .alu_ctrl_o(alu4), .alu_src_o(alu_src4), .imm_src_o(imm4), .pc_src_o(pcs4),
    .illegal_o(illegal4), .state_o(state4), .instret_o(instret4)
  );

  assign obs  = {state, mem_req, ir_we, pc_we, rw, mw, rs, pcs, alu, alu_src, imm, illegal};
  assign obs4 = {state4, mem_req4, ir_we4, pc_we4, rw4, mw4, rs4, pcs4, alu4, alu_src4, imm4, illegal4};

  typedef struct {
    string       tag;
    logic [21:0] v;
    logic [31:0] n;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam logic [31:0] ADDI = 32'h00500093, SW  = 32'h0020A023,
                          BNE  = 32'h00209463, JAL = 32'h0080006F,
                          LUI  = 32'h000010B7, LW  = 32'h0000A103,
                          BAD  = 32'h0000007F, BLTU = 32'h0020E463;

  function automatic logic [21:0] ev(input logic [2:0] st, input logic req, input logic irwe,
                                     input logic pcwe, input logic [1:0] rwc, input logic [1:0] mwc,
                                     input logic [1:0] rsc, input logic [1:0] pcc,
                                     input logic [2:0] aluc, input logic asrc,
                                     input logic [2:0] immc, input logic ill);
    return {st, req, irwe, pcwe, rwc, mwc, rsc, pcc, aluc, asrc, immc, ill};
  endfunction

  function automatic logic [21:0] f_e(input logic irwe, input logic ill);
    return ev(3'd0, 1'b1, irwe, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 3'b000, ill);
  endfunction

  function automatic logic [21:0] d_e();
    return ev(3'd1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0);
  endfunction

  // push the expectation, sample on the falling edge, pop and compare
  task automatic chk(input string tag, input logic [21:0] v, input logic [31:0] n);
    exp_t e;
    sb.push_back('{tag: tag, v: v, n: n});
    @(negedge clk);
    e = sb.pop_front();
    n_chk++;
    assert (obs === e.v) else begin
      n_fail++;
      $error("FAIL %s outputs: observed %h expected %h", e.tag, obs, e.v);
    end
    n_chk++;
    assert (instret === e.n) else begin
      n_fail++;
      $error("FAIL %s instret: observed %0d expected %0d", e.tag, instret, e.n);
    end
    n_chk++;
    assert (obs4 === e.v) else begin
      n_fail++;
      $error("FAIL %s outputs4: observed %h expected %h", e.tag, obs4, e.v);
    end
    n_chk++;
    assert (instret4 === e.n[3:0]) else begin
      n_fail++;
      $error("FAIL %s instret4: observed %0d expected %0d", e.tag, instret4, e.n[3:0]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; instr = 32'h0; rdy = 1'b1; zero = 1'b0; lt = 1'b0;
    @(posedge clk);
    #1;
    chk("reset", ev(3'd0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 3'b000, 0), 0);
    rst_n = 1'b1;

    instr = ADDI;
    chk("addi_f", f_e(1, 0), 0);
    chk("addi_d", d_e(), 0);
    chk("addi_e", ev(3'd2, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 3'b000, 0), 0);
    chk("addi_wb", ev(3'd4, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0, 3'b000, 0), 0);

    instr = SW;
    chk("sw_f", f_e(1, 0), 1);
    chk("sw_d", d_e(), 1);
    chk("sw_e", ev(3'd2, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 3'b001, 0), 1);
    rdy = 1'b0;
    repeat (3) chk("sw_wait", ev(3'd3, 1, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000, 0, 3'b000, 0), 1);
    rdy = 1'b1;
    chk("sw_done", ev(3'd3, 1, 0, 1, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000, 0, 3'b000, 0), 1);

    instr = BNE;
    chk("bne_f", f_e(1, 0), 2);
    chk("bne_d", d_e(), 2);
    zero = 1'b0;
    chk("bne_taken", ev(3'd2, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b001, 0, 3'b010, 0), 2);
    chk("bne2_f", f_e(1, 0), 3);
    chk("bne2_d", d_e(), 3);
    zero = 1'b1;
    chk("bne_not", ev(3'd2, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 0, 3'b010, 0), 3);
    zero = 1'b0;

    instr = JAL;
    chk("jal_f", f_e(1, 0), 4);
    chk("jal_d", d_e(), 4);
    chk("jal_e", ev(3'd2, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 3'b011, 0), 4);
    chk("jal_wb", ev(3'd4, 0, 0, 1, 2'b01, 2'b00, 2'b10, 2'b01, 3'b000, 0, 3'b011, 0), 4);

    instr = LUI;
    chk("lui_f", f_e(1, 0), 5);
    chk("lui_d", d_e(), 5);
    chk("lui_e", ev(3'd2, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 3'b100, 0), 5);
    chk("lui_wb", ev(3'd4, 0, 0, 1, 2'b01, 2'b00, 2'b11, 2'b00, 3'b000, 0, 3'b100, 0), 5);

    instr = LW;
    chk("lw_f", f_e(1, 0), 6);
    chk("lw_d", d_e(), 6);
    chk("lw_e", ev(3'd2, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 3'b000, 0), 6);
    rdy = 1'b0;
    repeat (2) chk("lw_wait", ev(3'd3, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 3'b000, 0), 6);
    rst_n = 1'b0;
    chk("lw_rst", ev(3'd3, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 3'b000, 0), 6);
    rst_n = 1'b1;
    repeat (2) chk("lw_after_rst", f_e(0, 0), 0);

    instr = BAD; rdy = 1'b1;
    chk("bad_f", f_e(1, 0), 0);
    chk("bad_d", d_e(), 0);
    repeat (10) chk("halt", ev(3'd5, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 3'b000, 1), 0);
    rst_n = 1'b0;
    chk("halt_rst", ev(3'd5, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 3'b000, 1), 0);
    rst_n = 1'b1; rdy = 1'b0;
    chk("halt_exit", f_e(0, 0), 0);

    instr = BLTU; rdy = 1'b1;
    chk("bltu_f", f_e(1, 0), 0);
    chk("bltu_d", d_e(), 0);
    chk("bltu_halt", ev(3'd5, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 3'b000, 1), 0);
    rst_n = 1'b0;
    chk("bltu_rst", ev(3'd5, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 3'b000, 1), 0);
    rst_n = 1'b1;

    instr = ADDI;
    for (int i = 0; i < 16; i++) begin
      chk("wrap_f", f_e(1, 0), 32'(i));
      chk("wrap_d", d_e(), 32'(i));
      chk("wrap_e", ev(3'd2, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 3'b000, 0), 32'(i));
      chk("wrap_wb", ev(3'd4, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0, 3'b000, 0), 32'(i));
    end
    chk("wrap_end", f_e(1, 0), 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
